prio_int_ctrl: RTL



---
 rtl/prio_int_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/prio_int_ctrl.sv
// Priority interrupt controller: masks and arbitrates NUM_SRC sources and runs the intr/int_ack/eoi handshake.
// Optional macro INT_IRQ_SYNC_EN adds a 2-flop synchroniser on irq_in.
module prio_int_ctrl #(
  parameter int unsigned       NUM_SRC  = 8,
  parameter int unsigned       ID_W     = 3,
  parameter int unsigned       VEC_W    = 32,
  parameter logic [VEC_W-1:0]  VEC_BASE = 'h100
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               cfg_wr,
  input  logic [1:0]         cfg_addr,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic [NUM_SRC-1:0] cfg_rdata,
  output logic               intr,
  input  logic               int_ack,
  input  logic               eoi,
  output logic [ID_W-1:0]    int_id,
  output logic [VEC_W-1:0]   int_vec
);

  localparam logic [1:0] A_MASK  = 2'd0;
  localparam logic [1:0] A_MODE  = 2'd1;
  localparam logic [1:0] A_PEND  = 2'd2;
  localparam logic [1:0] A_INSVC = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_e;

  state_e             state_q, state_d;
  logic               intr_q, intr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] irq_s;

`ifdef INT_IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  logic               wr_mask, wr_mode, wr_pend;
  logic               gnt_ack;
  logic [NUM_SRC-1:0] gnt_onehot, edge_set, edge_clr, elig, insvc;
  logic               win_any;
  logic [ID_W-1:0]    win_id;
  logic [VEC_W-1:0]   win_vec;

  assign wr_mask    = cfg_wr && (cfg_addr == A_MASK);
  assign wr_mode    = cfg_wr && (cfg_addr == A_MODE);
  assign wr_pend    = cfg_wr && (cfg_addr == A_PEND);
  assign gnt_ack    = (state_q == S_REQ) && int_ack;
  assign gnt_onehot = NUM_SRC'(1) << id_q;
  assign insvc      = (state_q == S_SERVICE) ? gnt_onehot : '0;
  assign elig       = pend_q & ~mask_q;

  // Edge channels latch a rising edge and hold it until W1C or grant; set beats clear.
  always_comb begin
    mask_d   = wr_mask ? cfg_wdata : mask_q;
    mode_d   = wr_mode ? cfg_wdata : mode_q;
    prev_d   = irq_s;
    edge_set = irq_s & ~prev_q;
    edge_clr = (wr_pend ? cfg_wdata : '0) | (gnt_ack ? gnt_onehot : '0);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode_q[i]) pend_d[i] = edge_set[i] | (pend_q[i] & ~edge_clr[i]);
      else           pend_d[i] = irq_s[i];
    end
  end

  // Fixed priority: scan downward so the lowest eligible index is the last one written.
  always_comb begin
    win_any = |elig;
    win_id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win_id = ID_W'(i);
    end
    win_vec = VEC_BASE + (VEC_W'(win_id) << 2);
  end

  always_comb begin
    state_d = state_q;
    intr_d  = intr_q;
    id_d    = id_q;
    vec_d   = vec_q;
    case (state_q)
      S_IDLE: begin
        if (win_any) begin
          state_d = S_REQ;
          intr_d  = 1'b1;
          id_d    = win_id;
          vec_d   = win_vec;
        end
      end
      S_REQ: begin
        // A newly arrived higher-priority source does not re-arbitrate here.
        if (int_ack) begin
          state_d = S_SERVICE;
          intr_d  = 1'b0;
        end else if (!elig[id_q]) begin
          state_d = S_IDLE;
          intr_d  = 1'b0;
        end
      end
      S_SERVICE: begin
        if (eoi) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        intr_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      intr_q  <= 1'b0;
      id_q    <= '0;
      vec_q   <= '0;
      mask_q  <= '1;
      mode_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      intr_q  <= intr_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
    end
  end

  always_comb begin
    case (cfg_addr)
      A_MASK:  cfg_rdata = mask_q;
      A_MODE:  cfg_rdata = mode_q;
      A_PEND:  cfg_rdata = pend_q;
      A_INSVC: cfg_rdata = insvc;
      default: cfg_rdata = '0;
    endcase
  end

  assign intr    = intr_q;
  assign int_id  = id_q;
  assign int_vec = vec_q;

endmodule
